// File: rtl/fifo_rd_stream.sv
// Turns the async FIFO read port (rinc/rempty/rdata) into a valid/ready stream via a 3-deep prefetch queue.
// Latency: first beat valid two cycles after rempty falls; one beat per cycle sustained.
// Backpressure: m_ready low holds m_data; reads stop once queued+inflight reaches 3. Optional FIFO_RD_STREAM_CNT_EN adds m_count.
module fifo_rd_stream #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 rclk,
    input  logic                 rrstn,
    input  logic                 fifo_rempty,
    input  logic [WIDTH-1:0]     fifo_rdata,
    output logic                 fifo_rinc,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [WIDTH-1:0]     m_data
`ifdef FIFO_RD_STREAM_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] m_count
`endif
);

    logic [WIDTH-1:0] queue [3];
    logic [1:0]       head;
    logic [1:0]       tail;
    logic [1:0]       occ;
    logic             inflight;
    logic             pop;
    logic [2:0]       pending;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    assign pending = {1'b0, occ} + {2'b00, inflight};

    // Gating with rrstn keeps the read request quiet while the FIFO itself is held in reset.
    assign fifo_rinc = rrstn & ~fifo_rempty & (pending < 3'd3);

    assign m_valid = (occ != 2'd0);
    assign m_data  = queue[head];
    assign pop     = m_valid & m_ready;

    always_ff @(posedge rclk or negedge rrstn) begin
        if (!rrstn) begin
            head     <= 2'd0;
            tail     <= 2'd0;
            occ      <= 2'd0;
            inflight <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                queue[i] <= '0;
            end
        end else begin
            inflight <= fifo_rinc;
            if (inflight) begin
                queue[tail] <= fifo_rdata;
                tail        <= ptr_inc(tail);
            end
            if (pop) begin
                head <= ptr_inc(head);
            end
            occ <= occ + {1'b0, inflight} - {1'b0, pop};
        end
    end

`ifdef FIFO_RD_STREAM_CNT_EN
    always_ff @(posedge rclk or negedge rrstn) begin
        if (!rrstn) begin
            m_count <= '0;
        end else if (pop) begin
            m_count <= m_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: behavioural FIFO read port, scoreboard on the stream side, vector table for latency.
module tb_fifo_rd_stream;

    localparam int WIDTH     = 8;
    localparam int CNT_WIDTH = 16;

    logic                 rclk = 1'b0;
    logic                 rrstn = 1'b1;
    logic                 fifo_rempty = 1'b1;
    logic [WIDTH-1:0]     fifo_rdata = '0;
    logic                 fifo_rinc;
    logic                 m_valid;
    logic                 m_ready = 1'b0;
    logic [WIDTH-1:0]     m_data;
`ifdef FIFO_RD_STREAM_CNT_EN
    logic [CNT_WIDTH-1:0] m_count;
`endif

    fifo_rd_stream #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
        .rclk        (rclk),
        .rrstn       (rrstn),
        .fifo_rempty (fifo_rempty),
        .fifo_rdata  (fifo_rdata),
        .fifo_rinc   (fifo_rinc),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data)
`ifdef FIFO_RD_STREAM_CNT_EN
        ,
        .m_count     (m_count)
`endif
    );

    always #5 rclk = ~rclk;

    int tests  = 0;
    int failed = 0;

    logic [WIDTH-1:0] fifo_q [$];
    logic [WIDTH-1:0] exp_q  [$];
    logic             hold_empty = 1'b0;

    logic             last_rinc, last_vld;
    logic [WIDTH-1:0] last_dat;
    logic             stall_prev = 1'b0;
    logic [WIDTH-1:0] stall_dat  = '0;
    int               cyc = 0;
    int               beats = 0;
    int               pops_since_rst = 0;
    int               first_beat_cyc = -1;
    int               last_beat_cyc  = -1;

    typedef struct {
        logic             rdy;
        logic             exp_rinc;
        logic             exp_vld;
        logic             chk_dat;
        logic [WIDTH-1:0] exp_dat;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic [WIDTH-1:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
    endtask

    // One clock: drive rempty, sample at negedge, model FIFO read data registered after the edge.
    task automatic tick();
        logic             s_rinc, s_vld, s_rdy;
        logic [WIDTH-1:0] s_dat, e;
        fifo_rempty = (fifo_q.size() == 0) || hold_empty;
        @(negedge rclk);
        s_rinc = fifo_rinc;
        s_vld  = m_valid;
        s_rdy  = m_ready;
        s_dat  = m_data;
        last_rinc = s_rinc;
        last_vld  = s_vld;
        last_dat  = s_dat;
        if (rrstn) begin
            chk("occ_bound", 32'({1'b0, dut.occ} + {2'b00, dut.inflight} <= 3'd3), 32'd1);
            if (stall_prev) begin
                chk("stall_hold", {23'd0, s_vld, s_dat}, {23'd0, 1'b1, stall_dat});
            end
            stall_prev = s_vld && !s_rdy;
            stall_dat  = s_dat;
        end
        if (s_vld && s_rdy) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", 32'(s_dat), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("beat_data", 32'(s_dat), 32'(e));
            end
            beats++;
            pops_since_rst++;
            if (first_beat_cyc < 0) first_beat_cyc = cyc;
            last_beat_cyc = cyc;
        end
        @(posedge rclk);
        #1;
        cyc++;
        if (s_rinc && fifo_q.size() > 0) fifo_rdata = fifo_q.pop_front();
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || fifo_q.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        chk(name, 32'(exp_q.size()), 32'd0);
        repeat (3) tick();
    endtask

    initial begin
        bit found;

        vecs[0] = '{rdy: 1'b1, exp_rinc: 1'b1, exp_vld: 1'b0, chk_dat: 1'b0, exp_dat: 8'h00};
        vecs[1] = '{rdy: 1'b1, exp_rinc: 1'b0, exp_vld: 1'b0, chk_dat: 1'b0, exp_dat: 8'h00};
        vecs[2] = '{rdy: 1'b1, exp_rinc: 1'b0, exp_vld: 1'b1, chk_dat: 1'b1, exp_dat: 8'hA5};
        vecs[3] = '{rdy: 1'b1, exp_rinc: 1'b0, exp_vld: 1'b0, chk_dat: 1'b0, exp_dat: 8'h00};
        vecs[4] = '{rdy: 1'b1, exp_rinc: 1'b0, exp_vld: 1'b0, chk_dat: 1'b0, exp_dat: 8'h00};

        // Reset values with a non-empty FIFO
        #2 rrstn = 1'b0;
        push(8'h5A);
        m_ready = 1'b1;
        tick();
        chk("rst_m_valid", 32'(last_vld), 32'd0);
        chk("rst_m_data", 32'(last_dat), 32'd0);
        chk("rst_fifo_rinc", 32'(last_rinc), 32'd0);
`ifdef FIFO_RD_STREAM_CNT_EN
        chk("rst_m_count", 32'(m_count), 32'd0);
`endif
        rrstn = 1'b1;
        tick();
        chk("post_rst_rinc", 32'(last_rinc), 32'd1);
        drain("post_rst_drain", 20);

        // Single word latency, table driven
        push(8'hA5);
        for (int i = 0; i < 5; i++) begin
            m_ready = vecs[i].rdy;
            tick();
            chk($sformatf("single_rinc[%0d]", i), 32'(last_rinc), 32'(vecs[i].exp_rinc));
            chk($sformatf("single_vld[%0d]", i), 32'(last_vld), 32'(vecs[i].exp_vld));
            if (vecs[i].chk_dat) chk($sformatf("single_dat[%0d]", i), 32'(last_dat), 32'(vecs[i].exp_dat));
        end

        // Full-rate stream
        for (int i = 0; i < 16; i++) push(8'(i));
        beats = 0;
        first_beat_cyc = -1;
        drain("full_rate_drain", 60);
        chk("full_rate_beats", 32'(beats), 32'd16);
        chk("full_rate_span", 32'(last_beat_cyc - first_beat_cyc), 32'd15);

        // Stall with a full queue, then drain
        for (int i = 0; i < 20; i++) push(8'h40 + 8'(i));
        beats = 0;
        m_ready = 1'b0;
        repeat (10) tick();
        chk("stall_occ", 32'(dut.occ), 32'd3);
        chk("stall_rinc", 32'(last_rinc), 32'd0);
        m_ready = 1'b1;
        tick();
        chk("drain_rinc_first_pop", 32'(last_rinc), 32'd0);
        tick();
        chk("drain_rinc_resume", 32'(last_rinc), 32'd1);
        drain("stall_drain", 80);
        chk("stall_beats", 32'(beats), 32'd20);

        // Mid-transfer reset at occ=2, inflight=1
        for (int i = 0; i < 8; i++) push(8'h80 + 8'(i));
        m_ready = 1'b0;
        found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            tick();
            if (dut.occ == 2'd2 && dut.inflight) found = 1'b1;
        end
        chk("midrst_setup", 32'(found), 32'd1);
        rrstn = 1'b0;
        #1;
        chk("midrst_m_valid", 32'(m_valid), 32'd0);
        fifo_q.delete();
        exp_q.delete();
        fifo_rdata = '0;
        stall_prev = 1'b0;
        pops_since_rst = 0;
        m_ready = 1'b1;
        tick();
        rrstn = 1'b1;
        tick();
        chk("midrst_no_stale", 32'(last_vld), 32'd0);
        for (int i = 0; i < 3; i++) push(8'hC0 + 8'(i));
        beats = 0;
        drain("midrst_drain", 30);
        chk("midrst_beats", 32'(beats), 32'd3);

        // Random ready and empty toggling over 1000 words
        for (int i = 0; i < 1000; i++) push(8'(i * 7 + 3));
        beats = 0;
        for (int n = 0; n < 20000 && beats < 1000; n++) begin
            m_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 9) == 0) hold_empty = ~hold_empty;
            tick();
        end
        hold_empty = 1'b0;
        chk("random_beats", 32'(beats), 32'd1000);
        chk("random_sb_empty", 32'(exp_q.size()), 32'd0);
        m_ready = 1'b0;
        tick();
`ifdef FIFO_RD_STREAM_CNT_EN
        chk("m_count", 32'(m_count), 32'(pops_since_rst % 65536));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
